// File: rtl/alt_pattern_gen.sv
// alt_pattern_gen: framed alternating-bit serial source.
// Emits len bits starting at level `first`. Each level is held for run+1 bits.
// hold stalls the frame. A one-cycle done pulse follows the last bit.
// Every output comes straight from a register.
module alt_pattern_gen #(
  parameter int CNT_W = 8,
  parameter int RUN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic             first,
  input  logic [RUN_W-1:0] run,
  input  logic             hold,
  output logic             a,
  output logic             a_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg,   state_next;
  logic [CNT_W-1:0] len_reg,     len_next;
  logic [RUN_W-1:0] run_reg,     run_next;
  logic [CNT_W-1:0] bcnt_reg,    bcnt_next;   // 1-based index of the bit on `a`
  logic [RUN_W-1:0] rcnt_reg,    rcnt_next;   // position of that bit inside its run
  logic             level_reg,   level_next;  // level of the bit on `a`
  logic             a_reg,       a_next;
  logic             valid_reg,   valid_next;
  logic             busy_reg,    busy_next;
  logic             done_reg,    done_next;

  // Level and run position of the bit that follows the one currently shown.
  logic             step_level;
  logic [RUN_W-1:0] step_rcnt;

  // Advance the run counter; the level flips once a run of run+1 bits is complete.
  always_comb begin
    step_level = level_reg;
    step_rcnt  = rcnt_reg + 1'b1;
    if (rcnt_reg == run_reg) begin
      step_level = ~level_reg;
      step_rcnt  = '0;
    end
  end

  // Next-state and next-output logic for the IDLE/SEND/DONE sequencer.
  always_comb begin
    state_next = state_reg;
    len_next   = len_reg;
    run_next   = run_reg;
    bcnt_next  = bcnt_reg;
    rcnt_next  = rcnt_reg;
    level_next = level_reg;
    a_next     = a_reg;
    valid_next = valid_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        a_next     = 1'b0;
        valid_next = 1'b0;
        busy_next  = 1'b0;
        if (start) begin
          if (len != '0) begin
            // The first bit is presented on the same edge that accepts start.
            len_next   = len;
            run_next   = run;
            level_next = first;
            a_next     = first;
            valid_next = 1'b1;
            busy_next  = 1'b1;
            bcnt_next  = {{(CNT_W-1){1'b0}}, 1'b1};
            rcnt_next  = '0;
            state_next = SEND;
          end else begin
            // An empty frame only produces the completion pulse.
            done_next  = 1'b1;
            state_next = DONE;
          end
        end
      end

      SEND: begin
        if (hold) begin
          // Stall: `a` keeps its value and all counters stay frozen.
          valid_next = 1'b0;
        end else if (bcnt_reg == len_reg) begin
          // The bit just shown was the last one.
          a_next     = 1'b0;
          valid_next = 1'b0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = DONE;
        end else begin
          bcnt_next  = bcnt_reg + 1'b1;
          rcnt_next  = step_rcnt;
          level_next = step_level;
          a_next     = step_level;
          valid_next = 1'b1;
        end
      end

      DONE: begin
        // The done pulse lasts one cycle; start is not sampled here.
        a_next     = 1'b0;
        valid_next = 1'b0;
        busy_next  = 1'b0;
        bcnt_next  = '0;
        rcnt_next  = '0;
        level_next = 1'b0;
        state_next = IDLE;
      end

      default: begin
        a_next     = 1'b0;
        valid_next = 1'b0;
        busy_next  = 1'b0;
        bcnt_next  = '0;
        rcnt_next  = '0;
        level_next = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything at once, dropping any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      len_reg   <= '0;
      run_reg   <= '0;
      bcnt_reg  <= '0;
      rcnt_reg  <= '0;
      level_reg <= 1'b0;
      a_reg     <= 1'b0;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      len_reg   <= len_next;
      run_reg   <= run_next;
      bcnt_reg  <= bcnt_next;
      rcnt_reg  <= rcnt_next;
      level_reg <= level_next;
      a_reg     <= a_next;
      valid_reg <= valid_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign a       = a_reg;
  assign a_valid = valid_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_alt_pattern_gen.sv
// Directed bench for alt_pattern_gen.
// Expected per-cycle outputs are queued when a step is driven.
// They are popped and compared one time unit after the clock edge.
module tb_alt_pattern_gen;

  localparam int CNT_W = 8;
  localparam int RUN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] len = '0;
  logic             first = 1'b0;
  logic [RUN_W-1:0] run = '0;
  logic             hold = 1'b0;
  logic             a, a_valid, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic  a;
    logic  v;
    logic  b;
    logic  d;
    string tag;
  } exp_t;

  exp_t sb[$];

  alt_pattern_gen #(.CNT_W(CNT_W), .RUN_W(RUN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .len     (len),
    .first   (first),
    .run     (run),
    .hold    (hold),
    .a       (a),
    .a_valid (a_valid),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Queue the expected outputs, clock once, then pop and compare.
  task automatic step(input logic ea, input logic ev, input logic eb, input logic ed, input string tag);
    exp_t e;
    e.a = ea; e.v = ev; e.b = eb; e.d = ed; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.tag, ".a"},       a,       e.a);
    chk({e.tag, ".a_valid"}, a_valid, e.v);
    chk({e.tag, ".busy"},    busy,    e.b);
    chk({e.tag, ".done"},    done,    e.d);
    $display("[%0t] %s a=%b v=%b busy=%b done=%b", $time, e.tag, a, a_valid, busy, done);
  endtask

  // Runs one frame and checks it cycle by cycle.
  // Cycle c (c=1 is the first bit) is stalled when hold_from <= c < hold_from+hold_cnt.
  // With spam set, start stays high and the frame parameters are scrambled during SEND and DONE.
  task automatic frame(input int n, input logic f, input int r, input int hold_from,
                       input int hold_cnt, input bit spam, output int trans, output int nvalid);
    logic exp_a;
    logic prev;
    int   k;
    int   c;
    bit   held;
    trans  = 0;
    nvalid = 0;
    start = 1'b1;
    len   = n[CNT_W-1:0];
    first = f;
    run   = r[RUN_W-1:0];
    if (n == 0) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, "zero_done");
    end else begin
      exp_a = f;
      step(exp_a, 1'b1, 1'b1, 1'b0, "bit1");
      prev = a;
      nvalid = 1;
      k = 1;
      c = 1;
      while (k < n) begin
        c++;
        start = spam;
        if (spam) begin
          len   = 8'd2;
          first = ~f;
          run   = 4'd7;
        end
        held = (c >= hold_from) && (c < hold_from + hold_cnt);
        hold = held;
        if (held) begin
          step(exp_a, 1'b0, 1'b1, 1'b0, "held");
        end else begin
          exp_a = f ^ (((k / (r + 1)) % 2) == 1);
          step(exp_a, 1'b1, 1'b1, 1'b0, "bit");
          k++;
        end
        if (a_valid) begin
          nvalid++;
          if (a != prev) trans++;
          prev = a;
        end
      end
      hold = 1'b0;
      start = spam;
      step(1'b0, 1'b0, 1'b0, 1'b1, "done");
    end
    // A start here arrives in the DONE cycle and must be ignored.
    start = spam;
    step(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    start = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, "idle2");
  endtask

  initial begin
    int tr;
    int nv;

    // Reset held from time zero
    #12;
    chk("rst.a", a, 1'b0);
    chk("rst.a_valid", a_valid, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0, "post_rst_idle");

    // Pure alternation: 010101
    frame(6, 1'b0, 0, 0, 0, 1'b0, tr, nv);
    chk_int("alt6.valid_count", nv, 6);
    chk_int("alt6.transitions", tr, 5);

    // Runs of three: 11100011
    frame(8, 1'b1, 2, 0, 0, 1'b0, tr, nv);
    chk_int("run2.transitions", tr, 2);

    // Hold during cycles 3 and 4
    frame(5, 1'b1, 0, 3, 2, 1'b0, tr, nv);
    chk_int("hold.valid_count", nv, 5);

    // Empty frame, with start asserted again in its DONE cycle
    frame(0, 1'b0, 0, 0, 0, 1'b1, tr, nv);

    // start and scrambled parameters during SEND and DONE are ignored
    frame(4, 1'b0, 1, 0, 0, 1'b1, tr, nv);
    chk_int("spam.valid_count", nv, 4);

    // Asynchronous reset while bit 3 of a len=10 frame is shown
    start = 1'b1;
    len = 8'd10;
    first = 1'b1;
    run = 4'd0;
    step(1'b1, 1'b1, 1'b1, 1'b0, "r10.bit1");
    start = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0, "r10.bit2");
    step(1'b1, 1'b1, 1'b1, 1'b0, "r10.bit3");
    #2;
    rst = 1'b1;
    #1;
    chk("arst.a", a, 1'b0);
    chk("arst.a_valid", a_valid, 1'b0);
    chk("arst.busy", busy, 1'b0);
    chk("arst.done", done, 1'b0);
    $display("[%0t] async reset a=%b v=%b busy=%b done=%b", $time, a, a_valid, busy, done);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 1'b0, "arst.idle");
    frame(10, 1'b1, 1, 0, 0, 1'b0, tr, nv);
    chk_int("fresh10.valid_count", nv, 10);
    chk_int("fresh10.transitions", tr, 4);

    // Longest frame with the longest run: 15 runs of 16 bits, then a final run of 15 bits
    frame(255, 1'b0, 15, 0, 0, 1'b0, tr, nv);
    chk_int("max.valid_count", nv, 255);
    chk_int("max.transitions", tr, 15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alt_pattern_gen.md
# alt_pattern_gen

Serial stimulus generator that emits framed alternating-bit sequences (0101…/1010…, optionally with runs of each level) on a single-bit line. It is the transmit end of the alternating zeros/ones serial line: its `a` output drives the serial input of the alternating-pattern detector FSMs in the FSM library. It is used as an on-chip pattern source and as bench stimulus.

## Interface
- `CNT_W`, default 8: width of the frame-length counter. The maximum frame is 2^CNT_W−1 bits.
- `RUN_W`, default 4: width of the run-length field.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `start`  in  1  frame request; sampled only in IDLE.
- `len`  in  CNT_W  number of bits in the frame; latched with `start`.
- `first`  in  1  level of the first bit; latched with `start`.
- `run`  in  RUN_W  each level is held run+1 bits; latched with `start`.
- `hold`  in  1  stall; freezes the frame while high.
- `a`  out  1  serial data (registered).
- `a_valid`  out  1  `a` carries a frame bit this cycle.
- `busy`  out  1  a frame is in progress (SEND state).
- `done`  out  1  one-cycle pulse when the frame completes.

## Operation
- States are IDLE, SEND and DONE. All outputs are registered.
- Reset forces the following immediately, at any time including mid-frame: state=IDLE, a=0, a_valid=0, busy=0, done=0, all counters=0. Any partial frame is discarded.
- IDLE:
  - If `start`=1 and `len`≠0: latch `len`, `first` and `run`, then go to SEND.
  - If `start`=1 and `len`=0: go to DONE. No bits are emitted.
  - Otherwise: stay in IDLE, with a=0 and a_valid=0.
- SEND: each non-held cycle emits one bit (a_valid=1).
  - Bit count `bcnt` counts 1..len.
  - Run counter `rcnt` counts 0..run. The level toggles after the bit where rcnt==run, and rcnt then wraps to 0.
  - Example: run=0 gives pure alternation. run=2 with first=1 gives 111000111…
  - After the bit where bcnt==len, go to DONE.
- `hold`=1 in SEND:
  - a_valid=0 and `a` keeps its last value.
  - bcnt, rcnt and the level are frozen.
  - Emission resumes on the first cycle after hold drops, with no bit lost or duplicated.
  - `hold` has no effect in IDLE or DONE.
- DONE: done=1, a=0, a_valid=0 for exactly one cycle, then IDLE. `start` is ignored in DONE and in SEND.
- Counter widths:
  - bcnt is CNT_W bits and cannot overflow, because len ≤ 2^CNT_W−1.
  - rcnt is RUN_W bits; run=2^RUN_W−1 is legal and gives runs of 2^RUN_W bits.
- Changes on `len`, `first` or `run` while busy have no effect on the current frame.

## Timing
- `start` accepted at edge T → first bit: a=first, a_valid=1, busy=1 in cycle T+1.
- With no hold, bit k (1-based) appears in cycle T+k.
- The last bit is in cycle T+len. done=1 and busy=0 in cycle T+len+1. IDLE is reached in T+len+2, where a new `start` is accepted.
- Each held cycle extends the frame and delays done by one cycle.
- len=0: done=1 in T+1, busy never asserts.
- Minimum start-to-start spacing is len+2 cycles.

## Test plan
- Reset, then start with len=6, first=0, run=0 → a=0,1,0,1,0,1 in cycles T+1..T+6 with a_valid=1; done pulses at T+7 only; a=0 afterwards.
- start with len=8, first=1, run=2 → a=1,1,1,0,0,0,1,1; busy high for 8 cycles; done at T+9.
- len=5, first=1, run=0, with hold=1 during cycles T+3..T+4 → valid bits 1,0,1,0,1 appear at T+1, T+2, T+5, T+6, T+7; a holds 0 while held; done at T+8.
- start with len=0 → done at T+1, a_valid never asserts; also start pulses during SEND and during the DONE cycle → ignored, with no second frame.
- Assert rst asynchronously at bit 3 of a len=10 frame → a=0, a_valid=0, busy=0 at once (before the next edge); after release a new start yields a full fresh frame.
- CNT_W=8, len=255, run=15, first=0 → 255 bits in runs of 16 (last run 15 bits); done at T+256; the bench detector fed from `a` sees the expected transition count.
